// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: grants one of the ALU/load result streams per cycle,
// registers the write port drive, and keeps a per-register pending (busy) scoreboard.
module regfile_wb_arbiter #(
   parameter int MEM_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aluValid,
   input  logic [4:0]  aluSel,
   input  logic [31:0] aluData,
   output logic        aluReady,
   input  logic        memValid,
   input  logic [4:0]  memSel,
   input  logic [31:0] memData,
   output logic        memReady,
   output logic        wCtrl,
   output logic [4:0]  wSel,
   output logic [31:0] wData,
   input  logic        busySet,
   input  logic [4:0]  busySel,
   input  logic [4:0]  rSel1,
   input  logic [4:0]  rSel2,
   output logic        rs1Busy,
   output logic        rs2Busy,
   output logic [7:0]  conflictCnt
);

   typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

   grant_e      lastGrant;
   logic [31:0] busy;
   logic [31:0] busyNext;
   logic        hs;
   logic [4:0]  hsSel;
   logic [31:0] hsData;
   logic        contest;

   assign contest = aluValid && memValid;

   // Grant is purely combinational so a lone requester completes in its own cycle.
   always_comb begin
      aluReady = 1'b0;
      memReady = 1'b0;
      if (contest) begin
         if (MEM_PRIORITY != 0)
            memReady = 1'b1;
         else if (lastGrant == GNT_MEM)
            aluReady = 1'b1;
         else
            memReady = 1'b1;
      end else if (aluValid) begin
         aluReady = 1'b1;
      end else if (memValid) begin
         memReady = 1'b1;
      end
   end

   always_comb begin
      hs     = aluReady || memReady;
      hsSel  = memReady ? memSel  : aluSel;
      hsData = memReady ? memData : aluData;
   end

   // A fresh issue to the same register outranks the retiring write.
   always_comb begin
      busyNext = busy;
      if (hs && hsSel != 5'd0)
         busyNext[hsSel] = 1'b0;
      if (busySet && busySel != 5'd0)
         busyNext[busySel] = 1'b1;
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wCtrl       <= 1'b0;
         wSel        <= 5'd0;
         wData       <= 32'd0;
         busy        <= 32'd0;
         lastGrant   <= GNT_MEM;
         conflictCnt <= 8'd0;
      end else begin
         wCtrl <= hs && (hsSel != 5'd0);
         if (hs) begin
            wSel      <= hsSel;
            wData     <= hsData;
            lastGrant <= memReady ? GNT_MEM : GNT_ALU;
         end
         busy <= busyNext;
         if (contest && conflictCnt != 8'hFF)
            conflictCnt <= conflictCnt + 8'd1;
      end
   end

   assign rs1Busy = (rSel1 != 5'd0) && busy[rSel1];
   assign rs2Busy = (rSel2 != 5'd0) && busy[rSel2];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_PRIORITY, default 1; 1 = load result wins every contested cycle, 0 = round-robin between the two requesters.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have ports aluValid in 1, aluSel in 5, aluData in 32 and aluReady out 1, the execute-result write request.
REQ-005 The block SHALL have ports memValid in 1, memSel in 5, memData in 32 and memReady out 1, the load-result write request.
REQ-006 The block SHALL have ports wCtrl out 1, wSel out 5 and wData out 32, the registered drive of the register file write port.
REQ-007 The block SHALL have ports busySet in 1 and busySel in 5, which mark a destination register as pending at issue.
REQ-008 The block SHALL have ports rSel1 in 5, rSel2 in 5, rs1Busy out 1 and rs2Busy out 1, the scoreboard query for the decode stage.
REQ-009 The block SHALL have port conflictCnt, out, 8, a saturating count of contested cycles.

Function
REQ-010 Grant SHALL be combinational: aluReady = granted to ALU; memReady = granted to MEM; at most one ready is high per cycle.
REQ-011 A single valid requester SHALL be granted in the same cycle.
REQ-012 When both are valid and MEM_PRIORITY=1, MEM SHALL be granted.
REQ-013 When both are valid and MEM_PRIORITY=0, the requester not granted most recently SHALL win; the lastGrant register updates on every handshake; reset value = MEM, so the ALU wins the first contest.
REQ-014 A requester not granted SHALL hold valid, sel and data stable until its ready is high; the block does not buffer losers.
REQ-015 On a handshake (valid and ready), the next cycle SHALL have wSel/wData = the granted sel/data and wCtrl = 1 if sel != 0, giving 1-cycle latency.
REQ-016 A handshake with sel = 0 SHALL complete normally (ready high) but SHALL produce wCtrl = 0; x0 is never written.
REQ-017 In a cycle without a handshake, the next cycle SHALL have wCtrl = 0, and wSel/wData SHALL hold their previous values.
REQ-018 Scoreboard: 32 busy bits; busy[0] SHALL be constant 0.
REQ-019 busySet=1 with busySel != 0 SHALL set busy[busySel] at the next edge.
REQ-020 A handshake with sel != 0 SHALL clear busy[sel] at the same edge that registers the write, so busy is already 0 in the cycle wCtrl=1.
REQ-021 When a set and a clear target the same register at the same edge, the set SHALL win, because a new producer was issued.
REQ-022 rs1Busy = busy[rSel1] and rs2Busy = busy[rSel2], combinational; rSel = 0 SHALL always return 0.
REQ-023 conflictCnt SHALL increment by 1 in each cycle where aluValid and memValid are both 1, and SHALL saturate at 255 without wrapping.

Reset
REQ-024 While rst=0 at a rising edge, the next state SHALL be: wCtrl=0, wSel=0, wData=0, all busy=0, lastGrant=MEM, conflictCnt=0.
REQ-025 A handshake occurring in the reset cycle SHALL be discarded (no wCtrl afterward), and a busySet in that cycle SHALL be ignored.
REQ-026 During reset, readys SHALL still follow REQ-010..013 combinationally, and requesters SHALL not rely on them.

Verification
REQ-027 Scenario, ALU only: aluValid=1, aluSel=5, aluData=0xDEADBEEF -> aluReady=1 same cycle; next cycle wCtrl=1, wSel=5, wData=0xDEADBEEF.
REQ-028 Scenario, contention with MEM_PRIORITY=1: both valid (ALU x3=0x11, MEM x4=0x22) for 2 cycles -> MEM granted cycle 1; ALU granted cycle 2 after MEM drops; writes x4 then x3; conflictCnt=1.
REQ-029 Scenario, round-robin with MEM_PRIORITY=0: both held valid for 4 cycles after reset -> grant order ALU, MEM, ALU, MEM; conflictCnt=4.
REQ-030 Scenario, scoreboard: busySet x7 -> rs1Busy=1 for rSel1=7 the next cycle; in the same cycle as a MEM x7 handshake, also busySet x7 -> busy[7] stays 1; a later handshake alone clears it.
REQ-031 Scenario, x0 write: aluSel=0, aluValid=1 -> aluReady=1, next cycle wCtrl=0; rs1Busy for rSel1=0 stays 0 after busySet x0.
REQ-032 Scenario, reset mid-operation: handshake to x9 and busy[9]=1, then rst=0 on that edge -> next cycle wCtrl=0, busy all 0, conflictCnt=0; 300 contested cycles afterward -> conflictCnt=255.
